// File: rtl/shift_reg_window.sv
// shift_reg_window: WIDTH x DEPTH shift-register window with parallel load,
// single-word shift-in and a saturating fill counter. Word 0 is the newest.
// Serves as the SHA-256 message-schedule window and as a general history buffer.
// Optional macro SHIFT_REG_WINDOW_TAPS_EN adds the fixed SHA-256 taps
// q_t2/q_t7/q_t15/q_t16 (words 1, 6, 14, 15); it requires DEPTH >= 16.
module shift_reg_window #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH*DEPTH-1:0]   d_par,
    output logic [WIDTH*DEPTH-1:0]   q_par,
    output logic [WIDTH-1:0]         q_head,
    output logic [WIDTH-1:0]         q_tail,
`ifdef SHIFT_REG_WINDOW_TAPS_EN
    output logic [WIDTH-1:0]         q_t2,
    output logic [WIDTH-1:0]         q_t7,
    output logic [WIDTH-1:0]         q_t15,
    output logic [WIDTH-1:0]         q_t16,
`endif
    output logic [CW-1:0]            count,
    output logic                     full
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    // Packed so that word i occupies bits [WIDTH*i +: WIDTH], matching d_par/q_par.
    logic [DEPTH-1:0][WIDTH-1:0] word_q;
    logic [DEPTH-1:0][WIDTH-1:0] word_d;
    logic                        word_en;
    logic [CW-1:0]               count_d;

    // One enable for every word register: any load or shift moves the whole window.
    assign word_en = load | shift;

    // Per-word next value: parallel data on load, otherwise the neighbour one step newer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        word_d = {word_q[DEPTH-2:0], d};
        if (load) begin
            word_d = d_par;
        end
    end

    // Fill level: jumps to DEPTH on load, saturates at DEPTH while shifting.
    always_comb begin
        count_d = count;
        if (load) begin
            count_d = COUNT_MAX;
        end else if (shift && (count != COUNT_MAX)) begin
            count_d = count + CW'(1);
        end
    end

    // Word storage: enable/clear registers, cleared asynchronously as a unit.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: the window is real state (not a RAM), so clearing it on reset is intended.
        if (clr) begin
            word_q <= '0;
        end else if (word_en) begin
            // NOTE: sequential state uses non-blocking assignments to avoid update-order races.
            word_q <= word_d;
        end
    end

    // Count and full are registered together so full always mirrors count == DEPTH.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_d;
            full  <= (count_d == COUNT_MAX);
        end
    end

    assign q_par  = word_q;
    assign q_head = word_q[0];
    assign q_tail = word_q[DEPTH-1];

`ifdef SHIFT_REG_WINDOW_TAPS_EN
    generate
        if (DEPTH < 16) begin : g_taps_depth_check
            $error("shift_reg_window: SHIFT_REG_WINDOW_TAPS_EN needs DEPTH >= 16");
        end
    endgenerate

    // SHA-256 taps relative to the next word W[t] to be shifted in.
    assign q_t2  = word_q[1];
    assign q_t7  = word_q[6];
    assign q_t15 = word_q[14];
    assign q_t16 = word_q[15];
`endif

endmodule

// File: tb/tb_shift_reg_window.sv
// tb_shift_reg_window: randomized and directed stimulus for shift_reg_window,
// compared every cycle against a queue-based model of the window.
module tb_shift_reg_window;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = WIDTH * DEPTH;

    logic             clk = 1'b0;
    logic             clr;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] d;
    logic [BW-1:0]    d_par;
    logic [BW-1:0]    q_par;
    logic [WIDTH-1:0] q_head;
    logic [WIDTH-1:0] q_tail;
    logic [CW-1:0]    count;
    logic             full;
`ifdef SHIFT_REG_WINDOW_TAPS_EN
    logic [WIDTH-1:0] q_t2, q_t7, q_t15, q_t16;
`endif

    shift_reg_window #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .shift  (shift),
        .d      (d),
        .d_par  (d_par),
        .q_par  (q_par),
        .q_head (q_head),
        .q_tail (q_tail),
`ifdef SHIFT_REG_WINDOW_TAPS_EN
        .q_t2   (q_t2),
        .q_t7   (q_t7),
        .q_t15  (q_t15),
        .q_t16  (q_t16),
`endif
        .count  (count),
        .full   (full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // Model: newest word at the front of the queue, always DEPTH entries long.
    logic [WIDTH-1:0] m_q[$];
    int               m_count;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
        m_count = 0;
    endfunction

    function automatic void m_apply(input logic l, input logic s,
                                    input logic [WIDTH-1:0] din, input logic [BW-1:0] dp);
        if (l) begin
            for (int i = 0; i < DEPTH; i++) m_q[i] = dp[WIDTH*i +: WIDTH];
            m_count = DEPTH;
        end else if (s) begin
            m_q.push_front(din);
            void'(m_q.pop_back());
            m_count = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
        end
    endfunction

    function automatic logic [BW-1:0] m_window();
        logic [BW-1:0] w;
        for (int i = 0; i < DEPTH; i++) w[WIDTH*i +: WIDTH] = m_q[i];
        return w;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < DEPTH; i++) b[WIDTH*i +: WIDTH] = $urandom;
        return b;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("q_par",  q_par,  m_window());
            check("q_head", q_head, m_q[0]);
            check("q_tail", q_tail, m_q[DEPTH-1]);
            check("count",  count,  m_count);
            check("full",   full,   m_count == DEPTH);
        end
    end

    // One clock with the given inputs; called at a negedge, returns at the next one.
    task automatic step(input logic l, input logic s,
                        input logic [WIDTH-1:0] din, input logic [BW-1:0] dp);
        load  = l;
        shift = s;
        d     = din;
        d_par = dp;
        @(posedge clk);
        if (!clr) m_apply(l, s, din, dp);
        @(negedge clk);
        load  = 1'b0;
        shift = 1'b0;
    endtask

    // Asynchronous clear between edges, held for some clocks with load/shift asserted.
    task automatic clr_pulse(input int hold);
        #2;
        clr = 1'b1;
        m_reset();
        #1;
        check("clr_async_q_par", q_par, '0);
        check("clr_async_count", count, '0);
        check("clr_async_full",  full,  1'b0);
        load  = 1'b1;
        shift = 1'b1;
        d     = $urandom;
        d_par = rand_block();
        repeat (hold) @(negedge clk);
        load  = 1'b0;
        shift = 1'b0;
        #2;
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0]    blk;
        logic [BW-1:0]    snap;
        logic [WIDTH-1:0] w;

        clr   = 1'b1;
        load  = 1'b0;
        shift = 1'b0;
        d     = '0;
        d_par = '0;
        m_reset();
        repeat (2) @(negedge clk);
        check("reset_q_par", q_par, '0);
        check("reset_count", count, '0);
        check("reset_full",  full,  1'b0);
        #2;
        clr = 1'b0;
        @(negedge clk);
        check_en = 1'b1;

        // Three shifts from reset.
        step(0, 1, 32'h1111_1111, '0);
        step(0, 1, 32'h2222_2222, '0);
        step(0, 1, 32'h3333_3333, '0);
        check("t1_head",  q_head, 32'h3333_3333);
        check("t1_word1", q_par[WIDTH*1 +: WIDTH], 32'h2222_2222);
        check("t1_word2", q_par[WIDTH*2 +: WIDTH], 32'h1111_1111);
        check("t1_count", count, 3);
        check("t1_full",  full, 1'b0);
        check("t1_tail",  q_tail, '0);

        // Load with shift also high: load wins.
        for (int i = 0; i < DEPTH; i++) blk[WIDTH*i +: WIDTH] = WIDTH'(i + 1);
        step(1, 1, 32'hDEAD_BEEF, blk);
        check("t2_q_par", q_par, blk);
        check("t2_count", count, DEPTH);
        check("t2_full",  full, 1'b1);

        // Clear mid-stream after a full load, then one shift.
        clr_pulse(2);
        step(0, 1, 32'h5555_AAAA, '0);
        check("t4_count", count, 1);
        check("t4_head",  q_head, 32'h5555_AAAA);

        // Shift 0..19 from reset: saturation and overwrite when full.
        clr_pulse(1);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, WIDTH'(k), '0);
            if (k == 14) check("t3_count15", count, 15);
            if (k == 14) check("t3_full15",  full, 1'b0);
            if (k == 15) check("t3_count16", count, DEPTH);
            if (k == 15) check("t3_full16",  full, 1'b1);
        end
        check("t3_head",  q_head, 19);
        check("t3_tail",  q_tail, 4);
        check("t3_count", count, DEPTH);

        // Idle with random data on the inputs.
        snap = m_window();
        for (int k = 0; k < 10; k++) step(0, 0, $urandom, rand_block());
        check("t5_q_par", q_par, snap);
        check("t5_count", count, DEPTH);

`ifdef SHIFT_REG_WINDOW_TAPS_EN
        for (int i = 0; i < DEPTH; i++) blk[WIDTH*i +: WIDTH] = WIDTH'(32'h100 + i);
        step(1, 0, '0, blk);
        check("t6_t2",  q_t2,  32'h101);
        check("t6_t7",  q_t7,  32'h106);
        check("t6_t15", q_t15, 32'h10E);
        check("t6_t16", q_t16, 32'h10F);
        step(0, 1, 32'hAA, '0);
        check("t6_t2s",  q_t2,  32'h100);
        check("t6_t16s", q_t16, 32'h10E);
`endif

        // Randomized traffic with occasional clears.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                clr_pulse($urandom_range(1, 3));
            end else begin
                w = $urandom;
                step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, w, rand_block());
            end
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
